// File: rtl/dmem_ctrl_pkg.sv
// Shared constants and types for the data-memory controller.
// Holds the bus-level constants used across the MEM stage and the FSM state codes.
// Also provides the word-alignment helper used for request qualification.
package dmem_ctrl_pkg;

  localparam int          REG_BUS       = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_BUSY = 2'b01,
    DMEM_DONE = 2'b10
  } dmem_state_e;

  // A byte address is usable only when it points at the start of a 32-bit word.
  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data RAM: synchronous write port, combinational read port.
// Write lands at the rising edge when we=1; read data follows ridx in the same cycle.
// Storage has no reset, so its contents survive a controller reset.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] widx,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] ridx,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Commit a store word on the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller between the MEM stage and the data RAM.
// Access takes WAIT_CYCLES+2 cycles (accept, WAIT_CYCLES busy, one DONE cycle).
// Stalls the pipeline from acceptance through the last busy cycle; request inputs held stable by that stall.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        flush_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        misalign_o
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  dmem_state_e           state, state_nxt;
  logic [3:0]            cnt;
  logic [31:0]           rdata_q;
  logic [31:0]           ram_rdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  commit;
  logic                  ram_we;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same words; they are deliberately dropped.
  assign idx            = mem_addr_i[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^mem_addr_i[31:DEPTH_LOG2+2];

  assign accept = (state == DMEM_IDLE) && (mem_ce_i == CHIP_ENABLE) &&
                  word_aligned(mem_addr_i) && !flush_i;
  // The access completes on the edge that ends the last busy cycle, unless flushed away.
  assign commit = (state == DMEM_BUSY) && (cnt == 4'd0) && !flush_i;
  assign ram_we = commit && (mem_we_i == WRITE_ENABLE);

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .widx  (idx),
    .wdata (mem_data_i),
    .ridx  (idx),
    .rdata (ram_rdata)
  );

  // State, wait counter and load-data capture; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DMEM_IDLE;
      cnt     <= 4'd0;
      rdata_q <= ZERO_WORD;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if ((state == DMEM_BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && (mem_we_i == WRITE_DISABLE)) rdata_q <= ram_rdata;
    end
  end

  // Next-state and output decode; DONE always returns to IDLE since the request is still on the inputs.
  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    mem_data_o = ZERO_WORD;
    unique case (state)
      DMEM_IDLE: begin
        misalign_o = (mem_ce_i == CHIP_ENABLE) && !word_aligned(mem_addr_i);
        if (accept) begin
          stallreq_o = 1'b1;
          state_nxt  = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        stallreq_o = 1'b1;
        if (flush_i)             state_nxt = DMEM_IDLE;
        else if (cnt == 4'd0)    state_nxt = DMEM_DONE;
      end
      DMEM_DONE: begin
        if (mem_we_i == WRITE_DISABLE) mem_data_o = rdata_q;
        state_nxt = DMEM_IDLE;
      end
      default: state_nxt = DMEM_IDLE;
    endcase
  end

endmodule
